// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, redirect kinds
// and the redirect priority order.
package fetch_pkg;

  localparam int          DATA_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    JR   = 2'd2,
    J    = 2'd3
  } pend_kind_e;

  // EX branches are older than ID jumps, so they win.
  function automatic logic [1:0] kind_prio(input pend_kind_e kind);
    case (kind)
      BR:      kind_prio = 2'd3;
      JR:      kind_prio = 2'd2;
      J:       kind_prio = 2'd1;
      default: kind_prio = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the IF select lines, ID redirect/instruction signals and the
// instruction-memory handshake around the fetch controller.
interface fetch_ctrl_if #(parameter int DATA_W = 32);

  logic              stall;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              id_jump;
  logic [DATA_W-1:0] id_jump_target;
  logic              id_jr;
  logic [DATA_W-1:0] id_jr_target;
  logic [DATA_W-1:0] pcnext;
  logic [DATA_W-1:0] pc;
  logic              pcvalid;
  logic              pcsrc;
  logic              jr;
  logic              jump;
  logic [DATA_W-1:0] pcbranch;
  logic [DATA_W-1:0] pcjr;
  logic [DATA_W-1:0] pcjump;
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] inst_pc;
  logic              inst_valid;

  modport master (
    input  stall, br_taken, br_target, id_jump, id_jump_target, id_jr, id_jr_target,
           pcnext, imem_gnt, imem_rvalid, imem_rdata,
    output pc, pcvalid, pcsrc, jr, jump, pcbranch, pcjr, pcjump,
           imem_req, imem_addr, inst, inst_pc, inst_valid
  );

  modport slave (
    output stall, br_taken, br_target, id_jump, id_jump_target, id_jr, id_jr_target,
           pcnext, imem_gnt, imem_rvalid, imem_rdata,
    input  pc, pcvalid, pcsrc, jr, jump, pcbranch, pcjr, pcjump,
           imem_req, imem_addr, inst, inst_pc, inst_valid
  );

endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// Priority select among simultaneous redirects plus the pending-redirect register.
// The eff_* outputs fold a same-cycle redirect into the pending one.
module redirect_arb
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic              br_taken_i,
  input  logic [DATA_W-1:0] br_target_i,
  input  logic              jr_i,
  input  logic [DATA_W-1:0] jr_target_i,
  input  logic              jump_i,
  input  logic [DATA_W-1:0] jump_target_i,
  output logic              redirect_o,
  output logic              eff_valid_o,
  output pend_kind_e        eff_kind_o,
  output logic [DATA_W-1:0] eff_target_o
);

  pend_kind_e        new_kind;
  logic [DATA_W-1:0] new_target;
  logic              accept;

  logic              pend_valid_q, pend_valid_d;
  pend_kind_e        pend_kind_q, pend_kind_d;
  logic [DATA_W-1:0] pend_target_q, pend_target_d;

  // A lower-priority redirect still counts as a redirect (it kills a fetch),
  // but never displaces an older pending one.
  always_comb begin
    new_kind      = NONE;
    new_target    = '0;
    if (br_taken_i) begin
      new_kind   = BR;
      new_target = br_target_i;
    end else if (jr_i) begin
      new_kind   = JR;
      new_target = jr_target_i;
    end else if (jump_i) begin
      new_kind   = J;
      new_target = jump_target_i;
    end

    redirect_o = enable_i && (new_kind != NONE);
    accept     = redirect_o &&
                 (!pend_valid_q || (kind_prio(new_kind) >= kind_prio(pend_kind_q)));

    eff_valid_o  = pend_valid_q || accept;
    eff_kind_o   = accept ? new_kind : pend_kind_q;
    eff_target_o = accept ? new_target : pend_target_q;

    pend_valid_d  = pend_valid_q;
    pend_kind_d   = pend_kind_q;
    pend_target_d = pend_target_q;
    if (clear_i) begin
      pend_valid_d = 1'b0;
      pend_kind_d  = NONE;
    end else if (accept) begin
      pend_valid_d  = 1'b1;
      pend_kind_d   = new_kind;
      pend_target_d = new_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q  <= 1'b0;
      pend_kind_q   <= NONE;
      pend_target_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_kind_q   <= pend_kind_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC register, runs a single-outstanding
// imem handshake and turns captured redirects into IF select lines.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              kill_q, kill_d;
  logic              update;
  logic              imem_req;
  logic              redirect;
  logic              eff_valid;
  pend_kind_e        eff_kind;
  logic [DATA_W-1:0] eff_target;

  redirect_arb #(.DATA_W(DATA_W)) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (state_q != BOOT),
    .clear_i       (update),
    .br_taken_i    (bus.br_taken),
    .br_target_i   (bus.br_target),
    .jr_i          (bus.id_jr),
    .jr_target_i   (bus.id_jr_target),
    .jump_i        (bus.id_jump),
    .jump_target_i (bus.id_jump_target),
    .redirect_o    (redirect),
    .eff_valid_o   (eff_valid),
    .eff_kind_o    (eff_kind),
    .eff_target_o  (eff_target)
  );

  // A redirect seen before the response lands marks that response as stale.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    update       = 1'b0;
    imem_req     = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) kill_d = 1'b1;
        if (bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (kill_q || redirect) begin
            update  = 1'b1;
            state_d = FETCH;
          end else begin
            inst_d       = bus.imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) inst_valid_d = 1'b0;
        if (!bus.stall) begin
          update       = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
    if (update) kill_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= bus.pcnext;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      kill_q       <= kill_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.pcvalid    = update;
  assign bus.pcsrc      = update && eff_valid && (eff_kind == BR);
  assign bus.jr         = update && eff_valid && (eff_kind == JR);
  assign bus.jump       = update && eff_valid && (eff_kind == J);
  assign bus.pcbranch   = eff_target;
  assign bus.pcjr       = eff_target;
  assign bus.pcjump     = eff_target;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scenario bench for fetch_ctrl: expected fetch addresses and instructions are
// queued when stimulus is driven and popped when the DUT produces them.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } inst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_addr_q[$];
  inst_t       exp_inst_q[$];

  fetch_ctrl_if #(.DATA_W(32)) bus ();

  fetch_ctrl #(.DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // IF next-PC mux as seen by the controller
  assign bus.pcnext = !bus.pcvalid ? bus.pc :
                      bus.pcsrc    ? bus.pcbranch :
                      bus.jr       ? bus.pcjr :
                      bus.jump     ? bus.pcjump : bus.pc + 32'd4;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.stall          = 1'b0;
    bus.br_taken       = 1'b0;
    bus.br_target      = '0;
    bus.id_jump        = 1'b0;
    bus.id_jump_target = '0;
    bus.id_jr          = 1'b0;
    bus.id_jr_target   = '0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    settle();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", bus.inst_valid); end
    checks++; if ({bus.inst, bus.inst_pc} !== 64'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h/%h expected 0/0", bus.inst, bus.inst_pc); end
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0000", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}); end
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0);
    settle();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_req: got %b expected 0", bus.imem_req); end
    tick();
    settle();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL boot_exit_req: got %b expected 1", bus.imem_req); end
  endtask

  task automatic test_basic();
    bit ok; logic [31:0] exp; inst_t e;
    exp = exp_addr_q.pop_front();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_req: got timeout expected imem_req"); end
    bus.imem_gnt = 1'b1;
    settle();
    checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL basic_addr: got %h expected %h", bus.imem_addr, exp); end
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2408_0001;
    e.data = 32'h2408_0001; e.pc = exp; exp_inst_q.push_back(e);
    settle();
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", bus.inst_valid); end
    tick();
    bus.imem_rvalid = 1'b0;
    settle();
    e = exp_inst_q.pop_front();
    checks++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, e.data, e.pc}) begin errors++; $display("[TB] FAIL basic_inst: got %b %h @%h expected 1 %h @%h", bus.inst_valid, bus.inst, bus.inst_pc, e.data, e.pc); end
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump} !== 4'b1000) begin errors++; $display("[TB] FAIL basic_update: got %b expected 1000", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}); end
    exp_addr_q.push_back(exp + 32'd4);
    tick();
    settle();
    checks++; if (bus.pc !== exp + 32'd4) begin errors++; $display("[TB] FAIL basic_pc4: got %h expected %h", bus.pc, exp + 32'd4); end
  endtask

  task automatic test_stall();
    bit ok; logic [31:0] exp; inst_t e;
    exp = exp_addr_q.pop_front();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_req: got timeout expected imem_req"); end
    bus.imem_gnt = 1'b1;
    settle();
    checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL stall_addr: got %h expected %h", bus.imem_addr, exp); end
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_0004;
    e.data = 32'h1111_0004; e.pc = exp; exp_inst_q.push_back(e);
    tick();
    bus.imem_rvalid = 1'b0; bus.stall = 1'b1;
    e = exp_inst_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, e.data, e.pc}) begin errors++; $display("[TB] FAIL stall_inst%0d: got %b %h @%h expected 1 %h @%h", i, bus.inst_valid, bus.inst, bus.inst_pc, e.data, e.pc); end
      checks++; if ({bus.pcvalid, bus.imem_req} !== 2'b00) begin errors++; $display("[TB] FAIL stall_quiet%0d: got %b expected 00", i, {bus.pcvalid, bus.imem_req}); end
      tick();
    end
    bus.stall = 1'b0;
    settle();
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump} !== 4'b1000) begin errors++; $display("[TB] FAIL stall_release: got %b expected 1000", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}); end
    exp_addr_q.push_back(exp + 32'd4);
    tick();
    settle();
    checks++; if (bus.pc !== exp + 32'd4) begin errors++; $display("[TB] FAIL stall_pc: got %h expected %h", bus.pc, exp + 32'd4); end
    tick();
    settle();
    checks++; if (bus.pc !== exp + 32'd4) begin errors++; $display("[TB] FAIL stall_pc_once: got %h expected %h", bus.pc, exp + 32'd4); end
  endtask

  task automatic test_jump_wait();
    bit ok; logic [31:0] exp;
    exp = exp_addr_q.pop_front();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL jmp_req: got timeout expected imem_req"); end
    bus.imem_gnt = 1'b1;
    settle();
    checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL jmp_addr: got %h expected %h", bus.imem_addr, exp); end
    tick();
    bus.imem_gnt = 1'b0; bus.id_jump = 1'b1; bus.id_jump_target = 32'h40;
    settle();
    checks++; if (bus.pcvalid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_early_update: got %b expected 0", bus.pcvalid); end
    tick();
    bus.id_jump = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hdead_beef;
    settle();
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump} !== 4'b1001) begin errors++; $display("[TB] FAIL jmp_sel: got %b expected 1001", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}); end
    checks++; if (bus.pcjump !== 32'h40) begin errors++; $display("[TB] FAIL jmp_target: got %h expected %h", bus.pcjump, 32'h40); end
    exp_addr_q.push_back(32'h40);
    tick();
    bus.imem_rvalid = 1'b0;
    settle();
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL jmp_squash: got %b expected 0", bus.inst_valid); end
  endtask

  task automatic test_priority();
    bit ok; logic [31:0] exp;
    exp = exp_addr_q.pop_front();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL prio_req: got timeout expected imem_req"); end
    bus.imem_gnt = 1'b1;
    settle();
    checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL prio_addr: got %h expected %h", bus.imem_addr, exp); end
    tick();
    bus.imem_gnt = 1'b0;
    bus.br_taken = 1'b1; bus.br_target = 32'h100;
    bus.id_jr = 1'b1; bus.id_jr_target = 32'h200;
    tick();
    bus.br_taken = 1'b0; bus.id_jr = 1'b0;
    bus.id_jump = 1'b1; bus.id_jump_target = 32'h300;
    tick();
    bus.id_jump = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0bad_0001;
    settle();
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump} !== 4'b1100) begin errors++; $display("[TB] FAIL prio_sel: got %b expected 1100", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}); end
    checks++; if (bus.pcbranch !== 32'h100) begin errors++; $display("[TB] FAIL prio_target: got %h expected %h", bus.pcbranch, 32'h100); end
    exp_addr_q.push_back(32'h100);
    tick();
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic test_gnt_delay();
    bit ok; logic [31:0] exp;
    exp = exp_addr_q.pop_front();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL gdly_req: got timeout expected imem_req"); end
    for (int i = 0; i < 4; i++) begin
      bus.id_jr = (i == 1);
      bus.id_jr_target = 32'h500;
      settle();
      checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp}) begin errors++; $display("[TB] FAIL gdly_hold%0d: got %b %h expected 1 %h", i, bus.imem_req, bus.imem_addr, exp); end
      tick();
    end
    bus.id_jr = 1'b0; bus.imem_gnt = 1'b1;
    settle();
    checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL gdly_addr: got %h expected %h", bus.imem_addr, exp); end
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hbad0_0000;
    settle();
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump} !== 4'b1010) begin errors++; $display("[TB] FAIL gdly_sel: got %b expected 1010", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}); end
    checks++; if (bus.pcjr !== 32'h500) begin errors++; $display("[TB] FAIL gdly_target: got %h expected %h", bus.pcjr, 32'h500); end
    exp_addr_q.push_back(32'h500);
    tick();
    bus.imem_rvalid = 1'b0;
    settle();
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL gdly_squash: got %b expected 0", bus.inst_valid); end
  endtask

  task automatic test_hold_redirect();
    bit ok; logic [31:0] exp; inst_t e;
    exp = exp_addr_q.pop_front();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hred_req: got timeout expected imem_req"); end
    bus.imem_gnt = 1'b1;
    settle();
    checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL hred_addr: got %h expected %h", bus.imem_addr, exp); end
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1234_5678;
    e.data = 32'h1234_5678; e.pc = exp; exp_inst_q.push_back(e);
    tick();
    bus.imem_rvalid = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h700;
    settle();
    e = exp_inst_q.pop_front();
    checks++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, e.data, e.pc}) begin errors++; $display("[TB] FAIL hred_inst: got %b %h @%h expected 1 %h @%h", bus.inst_valid, bus.inst, bus.inst_pc, e.data, e.pc); end
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump, bus.pcbranch} !== {4'b1100, 32'h700}) begin errors++; $display("[TB] FAIL hred_sel: got %b %h expected 1100 %h", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}, bus.pcbranch, 32'h700); end
    exp_addr_q.push_back(32'h700);
    tick();
    bus.br_taken = 1'b0;
    settle();
    checks++; if ({bus.inst_valid, bus.pc} !== {1'b0, 32'h700}) begin errors++; $display("[TB] FAIL hred_pc: got %b %h expected 0 %h", bus.inst_valid, bus.pc, 32'h700); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp; inst_t e;
    for (int k = 0; k < 3; k++) begin
      exp = exp_addr_q.pop_front();
      bus.imem_gnt = 1'b1;
      settle();
      checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, exp}) begin errors++; $display("[TB] FAIL b2b_req%0d: got %b %h expected 1 %h", k, bus.imem_req, bus.imem_addr, exp); end
      tick();
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'ha000_0000 + k;
      e.data = 32'ha000_0000 + k; e.pc = exp; exp_inst_q.push_back(e);
      tick();
      bus.imem_rvalid = 1'b0;
      settle();
      e = exp_inst_q.pop_front();
      checks++; if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.pcvalid} !== {1'b1, e.data, e.pc, 1'b1}) begin errors++; $display("[TB] FAIL b2b_inst%0d: got %b %h @%h pcvalid=%b expected 1 %h @%h pcvalid=1", k, bus.inst_valid, bus.inst, bus.inst_pc, bus.pcvalid, e.data, e.pc); end
      exp_addr_q.push_back(exp + 32'd4);
      tick();
    end
  endtask

  task automatic test_reset_midfetch();
    bit ok; logic [31:0] exp; inst_t e;
    exp = exp_addr_q.pop_front();
    bus.imem_gnt = 1'b1;
    settle();
    checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL rst_pre_addr: got %h expected %h", bus.imem_addr, exp); end
    tick();
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    settle();
    checks++; if ({bus.pc, bus.imem_req, bus.pcvalid} !== {32'h0, 2'b00}) begin errors++; $display("[TB] FAIL rst_async: got %h %b %b expected 0 0 0", bus.pc, bus.imem_req, bus.pcvalid); end
    tick();
    rst_n = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hffff_ffff;
    tick();
    settle();
    checks++; if ({bus.imem_req, bus.imem_addr, bus.pcvalid} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("[TB] FAIL rst_stale: got %b %h %b expected 1 0 0", bus.imem_req, bus.imem_addr, bus.pcvalid); end
    tick();
    bus.imem_rvalid = 1'b0;
    settle();
    checks++; if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 32'h0}) begin errors++; $display("[TB] FAIL rst_ignored: got %b %b %h expected 0 1 0", bus.inst_valid, bus.imem_req, bus.imem_addr); end
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_req: got timeout expected imem_req"); end
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h2408_0002;
    e.data = 32'h2408_0002; e.pc = 32'h0; exp_inst_q.push_back(e);
    tick();
    bus.imem_rvalid = 1'b0; bus.stall = 1'b1;
    bus.id_jump = 1'b1; bus.id_jump_target = 32'h80;
    settle();
    e = exp_inst_q.pop_front();
    checks++; if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.pcvalid} !== {1'b1, e.data, e.pc, 1'b0}) begin errors++; $display("[TB] FAIL rst_first_inst: got %b %h @%h pcvalid=%b expected 1 %h @%h pcvalid=0", bus.inst_valid, bus.inst, bus.inst_pc, bus.pcvalid, e.data, e.pc); end
    tick();
    bus.id_jump = 1'b0;
    settle();
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_drop: got %b expected 0", bus.inst_valid); end
    bus.stall = 1'b0;
    settle();
    checks++; if ({bus.pcvalid, bus.pcsrc, bus.jr, bus.jump, bus.pcjump} !== {4'b1001, 32'h80}) begin errors++; $display("[TB] FAIL hold_jump: got %b %h expected 1001 %h", {bus.pcvalid, bus.pcsrc, bus.jr, bus.jump}, bus.pcjump, 32'h80); end
    tick();
    settle();
    checks++; if (bus.pc !== 32'h80) begin errors++; $display("[TB] FAIL hold_jump_pc: got %h expected %h", bus.pc, 32'h80); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_jump_wait();
    test_priority();
    test_gnt_delay();
    test_hold_redirect();
    test_back_to_back();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
